// File: rtl/video_gen.sv
// Parametrised video timing and test-pattern generator: a raster position counter plus
// bars/grid/gradient/solid patterns, all outputs registered and aligned to one pixel.
module video_gen #(
   parameter int   H_ACTIVE = 640,
   parameter int   H_FP     = 16,
   parameter int   H_SYNC   = 96,
   parameter int   H_BP     = 48,
   parameter int   V_ACTIVE = 480,
   parameter int   V_FP     = 10,
   parameter int   V_SYNC   = 2,
   parameter int   V_BP     = 33,
   parameter logic HS_POL   = 1'b0,
   parameter logic VS_POL   = 1'b0,
   parameter int   PIX_SZ   = 4,
   parameter int   BAR_W    = 80,
   parameter int   GRID     = 32
) (
   input  logic                                                clk_i,
   input  logic                                                rstn_i,
   input  logic                                                en_i,
   input  logic [1:0]                                          mode_i,
   input  logic [3*PIX_SZ-1:0]                                 color_i,
   output logic [$clog2(H_ACTIVE+H_FP+H_SYNC+H_BP)-1:0]        hcount_o,
   output logic [$clog2(V_ACTIVE+V_FP+V_SYNC+V_BP)-1:0]        vcount_o,
   output logic                                                de_o,
   output logic                                                hsync_o,
   output logic                                                vsync_o,
   output logic                                                sof_o,
   output logic [7:0]                                          frame_o,
   output logic [PIX_SZ-1:0]                                   o_r,
   output logic [PIX_SZ-1:0]                                   o_g,
   output logic [PIX_SZ-1:0]                                   o_b
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HSZ     = $clog2(H_TOTAL);
   localparam int VSZ     = $clog2(V_TOTAL);
   localparam int BSZ     = (BAR_W > 1) ? $clog2(BAR_W) : 1;
   localparam int GSZ     = (GRID > 1) ? $clog2(GRID) : 1;

   localparam logic [HSZ-1:0] H_LAST     = HSZ'(H_TOTAL - 1);
   localparam logic [HSZ-1:0] H_ACT_LAST = HSZ'(H_ACTIVE - 1);
   localparam logic [HSZ-1:0] HS_FIRST   = HSZ'(H_ACTIVE + H_FP);
   localparam logic [HSZ-1:0] HS_LAST    = HSZ'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam logic [VSZ-1:0] V_LAST     = VSZ'(V_TOTAL - 1);
   localparam logic [VSZ-1:0] V_ACT_LAST = VSZ'(V_ACTIVE - 1);
   localparam logic [VSZ-1:0] VS_FIRST   = VSZ'(V_ACTIVE + V_FP);
   localparam logic [VSZ-1:0] VS_LAST    = VSZ'(V_ACTIVE + V_FP + V_SYNC - 1);
   localparam logic [BSZ-1:0] BAR_LAST   = BSZ'(BAR_W - 1);
   localparam logic [GSZ-1:0] GRID_LAST  = GSZ'(GRID - 1);

   // raster position and the wrap counters that track it
   logic [HSZ-1:0]      h_q, h_d;
   logic [VSZ-1:0]      v_q, v_d;
   logic [7:0]          frame_cnt_q, frame_cnt_d;
   logic [BSZ-1:0]      bar_px_q, bar_px_d;
   logic [2:0]          bar_k_q, bar_k_d;
   logic [GSZ-1:0]      hg_q, hg_d;
   logic [GSZ-1:0]      vg_q, vg_d;
   logic [1:0]          mode_sh_q, mode_sh_d;
   logic [3*PIX_SZ-1:0] color_sh_q, color_sh_d;

   // registered outputs
   logic [HSZ-1:0]      hcount_q, hcount_d;
   logic [VSZ-1:0]      vcount_q, vcount_d;
   logic                de_q, de_d;
   logic                hsync_q, hsync_d;
   logic                vsync_q, vsync_d;
   logic                sof_q, sof_d;
   logic [7:0]          frame_q, frame_d;
   logic [PIX_SZ-1:0]   r_q, r_d;
   logic [PIX_SZ-1:0]   g_q, g_d;
   logic [PIX_SZ-1:0]   b_q, b_d;

   logic                at_origin;
   logic [1:0]          mode_cur;
   logic [3*PIX_SZ-1:0] color_cur;
   logic                de_cur;
   logic                hs_cur;
   logic                vs_cur;
   logic                grid_on;
   logic [PIX_SZ-1:0]   pix_r;
   logic [PIX_SZ-1:0]   pix_g;
   logic [PIX_SZ-1:0]   pix_b;

   // at (0,0) the live inputs bypass the shadows so the first pixel already uses them
   always_comb begin
      at_origin = (h_q == '0) && (v_q == '0);
      mode_cur  = at_origin ? mode_i : mode_sh_q;
      color_cur = at_origin ? color_i : color_sh_q;
      de_cur    = (h_q <= H_ACT_LAST) && (v_q <= V_ACT_LAST);
      hs_cur    = (h_q >= HS_FIRST) && (h_q <= HS_LAST);
      vs_cur    = (v_q >= VS_FIRST) && (v_q <= VS_LAST);
      grid_on   = (hg_q == '0) || (vg_q == '0) || (h_q == H_ACT_LAST) || (v_q == V_ACT_LAST);
      pix_r     = '0;
      pix_g     = '0;
      pix_b     = '0;
      if (de_cur) begin
         case (mode_cur)
            2'd0: begin
               pix_r = {PIX_SZ{~bar_k_q[1]}};
               pix_g = {PIX_SZ{~bar_k_q[2]}};
               pix_b = {PIX_SZ{~bar_k_q[0]}};
            end
            2'd1: begin
               pix_r = {PIX_SZ{grid_on}};
               pix_g = {PIX_SZ{grid_on}};
               pix_b = {PIX_SZ{grid_on}};
            end
            2'd2: begin
               pix_r = h_q[PIX_SZ+3:4];
               pix_g = v_q[PIX_SZ+3:4];
            end
            default: {pix_r, pix_g, pix_b} = color_cur;
         endcase
      end
   end

   always_comb begin
      h_d         = h_q;
      v_d         = v_q;
      frame_cnt_d = frame_cnt_q;
      bar_px_d    = bar_px_q;
      bar_k_d     = bar_k_q;
      hg_d        = hg_q;
      vg_d        = vg_q;
      mode_sh_d   = mode_sh_q;
      color_sh_d  = color_sh_q;
      hcount_d    = hcount_q;
      vcount_d    = vcount_q;
      de_d        = de_q;
      hsync_d     = hsync_q;
      vsync_d     = vsync_q;
      sof_d       = sof_q;
      frame_d     = frame_q;
      r_d         = r_q;
      g_d         = g_q;
      b_d         = b_q;
      if (en_i) begin
         hcount_d = h_q;
         vcount_d = v_q;
         de_d     = de_cur;
         hsync_d  = hs_cur ? HS_POL : ~HS_POL;
         vsync_d  = vs_cur ? VS_POL : ~VS_POL;
         sof_d    = at_origin;
         frame_d  = frame_cnt_q;
         r_d      = pix_r;
         g_d      = pix_g;
         b_d      = pix_b;
         if (at_origin) begin
            mode_sh_d  = mode_i;
            color_sh_d = color_i;
         end
         if (h_q == H_LAST) begin
            h_d      = '0;
            bar_px_d = '0;
            bar_k_d  = '0;
            hg_d     = '0;
            if (v_q == V_LAST) begin
               v_d         = '0;
               vg_d        = '0;
               frame_cnt_d = frame_cnt_q + 8'd1;
            end else begin
               v_d  = v_q + 1'b1;
               vg_d = (vg_q == GRID_LAST) ? '0 : vg_q + 1'b1;
            end
         end else begin
            h_d  = h_q + 1'b1;
            hg_d = (hg_q == GRID_LAST) ? '0 : hg_q + 1'b1;
            if (bar_px_q == BAR_LAST) begin
               bar_px_d = '0;
               bar_k_d  = bar_k_q + 3'd1;
            end else begin
               bar_px_d = bar_px_q + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         h_q         <= '0;
         v_q         <= '0;
         frame_cnt_q <= '0;
         bar_px_q    <= '0;
         bar_k_q     <= '0;
         hg_q        <= '0;
         vg_q        <= '0;
         mode_sh_q   <= '0;
         color_sh_q  <= '0;
         hcount_q    <= '0;
         vcount_q    <= '0;
         de_q        <= 1'b0;
         hsync_q     <= ~HS_POL;
         vsync_q     <= ~VS_POL;
         sof_q       <= 1'b0;
         frame_q     <= '0;
         r_q         <= '0;
         g_q         <= '0;
         b_q         <= '0;
      end else begin
         h_q         <= h_d;
         v_q         <= v_d;
         frame_cnt_q <= frame_cnt_d;
         bar_px_q    <= bar_px_d;
         bar_k_q     <= bar_k_d;
         hg_q        <= hg_d;
         vg_q        <= vg_d;
         mode_sh_q   <= mode_sh_d;
         color_sh_q  <= color_sh_d;
         hcount_q    <= hcount_d;
         vcount_q    <= vcount_d;
         de_q        <= de_d;
         hsync_q     <= hsync_d;
         vsync_q     <= vsync_d;
         sof_q       <= sof_d;
         frame_q     <= frame_d;
         r_q         <= r_d;
         g_q         <= g_d;
         b_q         <= b_d;
      end
   end

   assign hcount_o = hcount_q;
   assign vcount_o = vcount_q;
   assign de_o     = de_q;
   assign hsync_o  = hsync_q;
   assign vsync_o  = vsync_q;
   assign sof_o    = sof_q;
   assign frame_o  = frame_q;
   assign o_r      = r_q;
   assign o_g      = g_q;
   assign o_b      = b_q;

endmodule

// File: tb/tb_video_gen.sv
// Scoreboard bench for video_gen: a small-raster instance under random enable/mode/colour with
// a mid-frame reset, and a default 640x480 instance over its first lines with an enable stall.
module tb_video_gen;

   typedef struct packed {
      logic [9:0] h;
      logic [9:0] v;
      logic       de;
      logic       hs;
      logic       vs;
      logic       sof;
      logic [7:0] frame;
      logic [3:0] r;
      logic [3:0] g;
      logic [3:0] b;
   } exp_t;

   typedef struct {
      int ha, hf, hs, hb, va, vf, vs, vb;
      bit hpol, vpol;
      int psz, barw, grid;
   } cfg_t;

   typedef struct {
      int         x, y, frame;
      logic [1:0] mode;
      logic [11:0] color;
      exp_t       last;
   } mstate_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   bit done_a = 1'b0;
   bit done_b = 1'b0;
   exp_t qa[$];
   exp_t qb[$];

   // small raster instance
   logic       rstn_a = 1'b1, en_a = 1'b0;
   logic [1:0] mode_a = 2'd0;
   logic [5:0] color_a = 6'd0;
   logic [5:0] hcount_a, vcount_a;
   logic       de_a, hsync_a, vsync_a, sof_a;
   logic [7:0] frame_a;
   logic [1:0] r_a, g_a, b_a;

   // default 640x480 instance
   logic        rstn_b = 1'b1, en_b = 1'b0;
   logic [1:0]  mode_b = 2'd0;
   logic [11:0] color_b = 12'd0;
   logic [9:0]  hcount_b, vcount_b;
   logic        de_b, hsync_b, vsync_b, sof_b;
   logic [7:0]  frame_b;
   logic [3:0]  r_b, g_b, b_b;

   video_gen #(
      .H_ACTIVE(40), .H_FP(4), .H_SYNC(6), .H_BP(6),
      .V_ACTIVE(30), .V_FP(2), .V_SYNC(3), .V_BP(5),
      .HS_POL(1'b1), .VS_POL(1'b1), .PIX_SZ(2), .BAR_W(5), .GRID(8)
   ) dut_a (
      .clk_i(clk), .rstn_i(rstn_a), .en_i(en_a), .mode_i(mode_a), .color_i(color_a),
      .hcount_o(hcount_a), .vcount_o(vcount_a), .de_o(de_a), .hsync_o(hsync_a),
      .vsync_o(vsync_a), .sof_o(sof_a), .frame_o(frame_a), .o_r(r_a), .o_g(g_a), .o_b(b_a)
   );

   video_gen dut_b (
      .clk_i(clk), .rstn_i(rstn_b), .en_i(en_b), .mode_i(mode_b), .color_i(color_b),
      .hcount_o(hcount_b), .vcount_o(vcount_b), .de_o(de_b), .hsync_o(hsync_b),
      .vsync_o(vsync_b), .sof_o(sof_b), .frame_o(frame_b), .o_r(r_b), .o_g(g_b), .o_b(b_b)
   );

   function automatic cfg_t cfg_a();
      cfg_t c;
      c.ha = 40; c.hf = 4; c.hs = 6; c.hb = 6;
      c.va = 30; c.vf = 2; c.vs = 3; c.vb = 5;
      c.hpol = 1'b1; c.vpol = 1'b1;
      c.psz = 2; c.barw = 5; c.grid = 8;
      return c;
   endfunction

   function automatic cfg_t cfg_b();
      cfg_t c;
      c.ha = 640; c.hf = 16; c.hs = 96; c.hb = 48;
      c.va = 480; c.vf = 10; c.vs = 2; c.vb = 33;
      c.hpol = 1'b0; c.vpol = 1'b0;
      c.psz = 4; c.barw = 80; c.grid = 32;
      return c;
   endfunction

   // colour bars left to right as {r,g,b} on/off
   function automatic logic [2:0] bar_rgb(int k);
      case (k)
         0:       return 3'b111;
         1:       return 3'b110;
         2:       return 3'b011;
         3:       return 3'b010;
         4:       return 3'b101;
         5:       return 3'b100;
         6:       return 3'b001;
         default: return 3'b000;
      endcase
   endfunction

   function automatic exp_t reset_exp(cfg_t c);
      exp_t e;
      e    = '0;
      e.hs = !c.hpol;
      e.vs = !c.vpol;
      return e;
   endfunction

   function automatic exp_t model_pixel(cfg_t c, int x, int y, logic [1:0] mode,
                                        logic [11:0] color, int frame);
      exp_t e;
      int maxv, hs0, vs0, cr, cg, cb, col;
      logic [2:0] bits;
      logic white;
      maxv = (1 << c.psz) - 1;
      hs0 = c.ha + c.hf;
      vs0 = c.va + c.vf;
      e.h = 10'(x);
      e.v = 10'(y);
      e.de = (x < c.ha) && (y < c.va);
      e.hs = ((x >= hs0) && (x < hs0 + c.hs)) ? c.hpol : !c.hpol;
      e.vs = ((y >= vs0) && (y < vs0 + c.vs)) ? c.vpol : !c.vpol;
      e.sof = (x == 0) && (y == 0);
      e.frame = 8'(frame);
      cr = 0; cg = 0; cb = 0;
      col = int'(color);
      if (e.de) begin
         case (mode)
            2'd0: begin
               bits = bar_rgb((x / c.barw) % 8);
               cr = bits[2] ? maxv : 0;
               cg = bits[1] ? maxv : 0;
               cb = bits[0] ? maxv : 0;
            end
            2'd1: begin
               white = (x % c.grid == 0) || (y % c.grid == 0) || (x == c.ha - 1) || (y == c.va - 1);
               cr = white ? maxv : 0;
               cg = cr;
               cb = cr;
            end
            2'd2: begin
               cr = (x >> 4) & maxv;
               cg = (y >> 4) & maxv;
            end
            default: begin
               cr = (col >> (2 * c.psz)) & maxv;
               cg = (col >> c.psz) & maxv;
               cb = col & maxv;
            end
         endcase
      end
      e.r = 4'(cr);
      e.g = 4'(cg);
      e.b = 4'(cb);
      return e;
   endfunction

   function automatic mstate_t reset_state(cfg_t c);
      mstate_t s;
      s.x = 0; s.y = 0; s.frame = 0;
      s.mode = 2'd0; s.color = 12'd0;
      s.last = reset_exp(c);
      return s;
   endfunction

   // expected output after the coming edge; a disabled edge repeats the previous output
   task automatic step(input cfg_t c, inout mstate_t s, input logic en, input logic [1:0] mode,
                       input logic [11:0] color, output exp_t e);
      int htot, vtot;
      htot = c.ha + c.hf + c.hs + c.hb;
      vtot = c.va + c.vf + c.vs + c.vb;
      if (!en) begin
         e = s.last;
      end else begin
         if (s.x == 0 && s.y == 0) begin
            s.mode  = mode;
            s.color = color;
         end
         e = model_pixel(c, s.x, s.y, s.mode, s.color, s.frame);
         s.last = e;
         if (s.x == htot - 1) begin
            s.x = 0;
            if (s.y == vtot - 1) begin
               s.y = 0;
               s.frame = (s.frame + 1) % 256;
            end else begin
               s.y = s.y + 1;
            end
         end else begin
            s.x = s.x + 1;
         end
      end
   endtask

   function automatic string fmt(exp_t e);
      return $sformatf("h=%0d v=%0d de=%b hs=%b vs=%b sof=%b fr=%0d rgb=%h/%h/%h",
                       e.h, e.v, e.de, e.hs, e.vs, e.sof, e.frame, e.r, e.g, e.b);
   endfunction

   function automatic exp_t act_a();
      exp_t e;
      e.h = 10'(hcount_a); e.v = 10'(vcount_a);
      e.de = de_a; e.hs = hsync_a; e.vs = vsync_a; e.sof = sof_a; e.frame = frame_a;
      e.r = 4'(r_a); e.g = 4'(g_a); e.b = 4'(b_a);
      return e;
   endfunction

   function automatic exp_t act_b();
      exp_t e;
      e.h = hcount_b; e.v = vcount_b;
      e.de = de_b; e.hs = hsync_b; e.vs = vsync_b; e.sof = sof_b; e.frame = frame_b;
      e.r = r_b; e.g = g_b; e.b = b_b;
      return e;
   endfunction

   task automatic checkOutput(input string tag, input exp_t act, input exp_t exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s @%0t got %s expected %s", tag, $time, fmt(act), fmt(exp));
      end
   endtask

   task automatic checkCount(input string tag, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("[TB] FAIL %s got %0d expected %0d", tag, act, exp);
      end
   endtask

   // instance A: random enable, mode and colour, with an asynchronous reset mid-frame
   initial begin : drive_a
      mstate_t s;
      exp_t e;
      s = reset_state(cfg_a());
      #1 rstn_a = 1'b0;
      #1 checkOutput("A power-up reset", act_a(), reset_exp(cfg_a()));
      @(negedge clk);
      rstn_a = 1'b1;
      for (int n = 0; n < 25000; n++) begin
         if (n == 5123) begin
            #3 rstn_a = 1'b0;
            #1 checkOutput("A async reset", act_a(), reset_exp(cfg_a()));
            s = reset_state(cfg_a());
            repeat (3) @(negedge clk);
            rstn_a = 1'b1;
         end
         en_a    = ($urandom_range(0, 9) < 8);
         mode_a  = 2'($urandom_range(0, 3));
         color_a = 6'($urandom);
         step(cfg_a(), s, en_a, mode_a, 12'(color_a), e);
         qa.push_back(e);
         @(negedge clk);
      end
      done_a = 1'b1;
   end

   // instance B: default timing, bars on the first frame, 10-cycle stall at x=100 of line 0
   initial begin : drive_b
      mstate_t s;
      exp_t e;
      int stall;
      stall = 0;
      s = reset_state(cfg_b());
      #1 rstn_b = 1'b0;
      #1 checkOutput("B power-up reset", act_b(), reset_exp(cfg_b()));
      @(negedge clk);
      rstn_b = 1'b1;
      for (int n = 0; n < 2000; n++) begin
         if (s.x == 100 && s.y == 0 && stall < 10) begin
            en_b = 1'b0;
            stall++;
         end else begin
            en_b = 1'b1;
         end
         mode_b  = (s.x == 0 && s.y == 0) ? 2'd0 : 2'($urandom_range(0, 3));
         color_b = 12'($urandom);
         step(cfg_b(), s, en_b, mode_b, color_b, e);
         qb.push_back(e);
         @(negedge clk);
      end
      done_b = 1'b1;
   end

   initial begin : monitor_a
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (qa.size() > 0) begin
            e = qa.pop_front();
            checkOutput("A pixel", act_a(), e);
         end
      end
   end

   initial begin : monitor_b
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (qb.size() > 0) begin
            e = qb.pop_front();
            checkOutput("B pixel", act_b(), e);
         end
      end
   end

   initial begin : finish_run
      wait (done_a && done_b);
      @(posedge clk);
      #2;
      checkCount("A queue drained", qa.size(), 0);
      checkCount("B queue drained", qb.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin : watchdog
      #2000000;
      errors++;
      $display("[TB] FAIL watchdog timeout got running expected finished");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $fatal(1, "[TB] timeout");
   end

endmodule
